// File: rtl/button_debounce_pkg.sv
// Shared FSM state encoding and default timing constants for the push-button debouncer.
// Imported by button_debounce and its testbench.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        REL     = 2'b00,
        WAIT_LO = 2'b01,
        PRS     = 2'b10,
        WAIT_HI = 2'b11
    } db_state_t;

    // 10 ms debounce and 1 s hold at a 50 MHz clk
    localparam int DB_CYCLES_DEF   = 500000;
    localparam int LONG_CYCLES_DEF = 50000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous switch inputs, resets to 1 (released).
// Latency: 2 clk edges. No backpressure: free-running level path.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Debounces an active-low push-button; BUTTON_DEBOUNCE_LONG_PRESS_EN adds a held-press pulse.
// Latency: 2+DB_CYCLES clk edges from first sampling of a stable level to B_clean.
// No backpressure: level in, registered level and one-cycle pulse out.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic B_in,
    output logic B_clean,
    output logic long_press
);

    localparam int DBW = $clog2(DB_CYCLES) + 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    logic           b_sync;
    db_state_t      state, state_nxt;
    logic [DBW-1:0] db_cnt, db_cnt_nxt;
    logic           clean_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (B_in),
        .q   (b_sync)
    );

    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        case (state)
            REL: begin
                if (!b_sync) begin
                    state_nxt  = WAIT_LO;
                    db_cnt_nxt = '0;
                end
            end
            WAIT_LO: begin
                if (b_sync) begin
                    state_nxt  = REL;
                    db_cnt_nxt = '0;
                end else if (db_cnt >= DB_LAST) begin
                    state_nxt  = PRS;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            PRS: begin
                if (b_sync) begin
                    state_nxt  = WAIT_HI;
                    db_cnt_nxt = '0;
                end
            end
            WAIT_HI: begin
                if (!b_sync) begin
                    state_nxt  = PRS;
                end else if (db_cnt >= DB_LAST) begin
                    state_nxt  = REL;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt  = REL;
                db_cnt_nxt = '0;
            end
        endcase
        // Accepted-pressed covers WAIT_HI so a release bounce never shows on B_clean
        clean_nxt = !((state_nxt == PRS) || (state_nxt == WAIT_HI));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= REL;
            db_cnt  <= '0;
            B_clean <= 1'b1;
        end else begin
            state   <= state_nxt;
            db_cnt  <= db_cnt_nxt;
            B_clean <= clean_nxt;
        end
    end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_cnt;

    // Count survives a WAIT_HI bounce; stops at LONG_CYCLES so the pulse fires once per press
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if ((state_nxt == REL) || (state_nxt == WAIT_LO)) begin
                hold_cnt <= '0;
            end else if ((state == PRS) && (hold_cnt <= HOLD_LAST)) begin
                hold_cnt   <= hold_cnt + 1'b1;
                long_press <= (hold_cnt == HOLD_LAST);
            end
        end
    end
`else
    // Hold logic compiled out; this expression is constant 0 for any legal LONG_CYCLES
    assign long_press = (LONG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce with DB_CYCLES=4, LONG_CYCLES=8 and a 20 ns clock.
// Segment table with end-of-segment levels, plus a per-edge scoreboard and directed corner sequences.
module tb_button_debounce;
    localparam int DB   = 4;
    localparam int LONG = 8;

    typedef struct {
        logic r;
        logic b;
        int   cycles;
        logic exp_clean;
    } seg_t;

    typedef struct {
        logic clean;
        logic lp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic B_in = 1'b1;
    logic B_clean;
    logic long_press;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_q[$];
    seg_t tbl[$];

    // Reference model: accepted level flips once the last DB+1 synchronized samples all disagree with it
    logic        m_s1 = 1'b1, m_s2 = 1'b1, m_seen_prev = 1'b1;
    logic        m_clean = 1'b1, m_long = 1'b0;
    logic [DB:0] m_hist = '1;
    int          m_hold = 0;

    button_debounce #(.DB_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
        .clk        (clk),
        .rst        (rst),
        .B_in       (B_in),
        .B_clean    (B_clean),
        .long_press (long_press)
    );

    always #10 clk = ~clk;

    function automatic void check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_edge(input logic r, input logic b);
        logic prior_prs;
        logic sync_now;
        if (!r) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_seen_prev = 1'b1;
            m_hist = '1; m_clean = 1'b1; m_hold = 0; m_long = 1'b0;
        end else begin
            prior_prs = !m_clean && !m_seen_prev;
            sync_now  = m_s2;
            m_hist    = {m_hist[DB-1:0], sync_now};
            if (m_clean && (m_hist == '0))
                m_clean = 1'b0;
            else if (!m_clean && (m_hist == '1))
                m_clean = 1'b1;
            m_long = 1'b0;
            if (m_clean) begin
                m_hold = 0;
            end else if (prior_prs) begin
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
                m_long = (m_hold == LONG - 1);
`endif
                if (m_hold < LONG) m_hold++;
            end
            m_seen_prev = sync_now;
            m_s2 = m_s1;
            m_s1 = b;
        end
    endfunction

    task automatic step(input logic r, input logic b);
        exp_t e;
        rst  = r;
        B_in = b;
        model_edge(r, b);
        @(posedge clk);
        #1;
        e.clean = m_clean;
        e.lp    = m_long;
        sb_q.push_back(e);
    endtask

    function automatic void add(input logic r, input logic b, input int n, input logic c);
        seg_t s;
        s.r = r; s.b = b; s.cycles = n; s.exp_clean = c;
        tbl.push_back(s);
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_clean", int'(B_clean), int'(e.clean));
            check("sb_long", int'(long_press), int'(e.lp));
        end
    end

    initial begin
        int fall_k, rise_k, long_k, n_long, n_fall, n_rise, exp_long_n;
        logic prev, b;

        // reset with button held, then first press and release
        add(0, 0, 4, 1);
        add(1, 0, 6, 1); add(1, 0, 1, 0); add(1, 0, 10, 0);
        add(1, 1, 6, 0); add(1, 1, 1, 1); add(1, 1, 5, 1);
        // press held exactly 10 cycles, then release
        add(1, 0, 6, 1); add(1, 0, 1, 0); add(1, 0, 3, 0);
        add(1, 1, 6, 0); add(1, 1, 1, 1); add(1, 1, 3, 1);
        // 3-cycle glitch then 2-cycle bouncing
        add(1, 0, 3, 1);
        for (int i = 0; i < 3; i++) begin
            add(1, 1, 2, 1); add(1, 0, 2, 1);
        end
        add(1, 1, 8, 1);
        // pulse of exactly DB samples is rejected, DB+1 is accepted
        add(1, 0, 4, 1); add(1, 1, 8, 1);
        add(1, 0, 5, 1); add(1, 1, 1, 1); add(1, 1, 1, 0);
        add(1, 1, 4, 0); add(1, 1, 1, 1); add(1, 1, 4, 1);
        // reset two edges into WAIT_LO, button still pressed
        add(1, 0, 4, 1); add(0, 0, 2, 1);
        add(1, 0, 6, 1); add(1, 0, 1, 0); add(1, 0, 3, 0);
        add(1, 1, 6, 0); add(1, 1, 1, 1);

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].cycles; c++) step(tbl[i].r, tbl[i].b);
            check($sformatf("seg%0d_clean", i), int'(B_clean), int'(tbl[i].exp_clean));
        end

        // held press: latency, long-press timing and count, release latency
        for (int i = 0; i < 8; i++) step(1, 1);
        fall_k = -1; long_k = -1; n_long = 0;
        for (int k = 0; k < 40; k++) begin
            step(1, 0);
            if (B_clean == 1'b0 && fall_k < 0) fall_k = k;
            if (long_press) begin
                n_long++;
                if (long_k < 0) long_k = k;
            end
        end
        check("press_latency", fall_k, 2 + DB);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        exp_long_n = 1;
        check("long_delay", long_k - fall_k, LONG);
`else
        exp_long_n = 0;
`endif
        check("long_count_held", n_long, exp_long_n);
        rise_k = -1;
        for (int k = 0; k < 12; k++) begin
            step(1, 1);
            if (B_clean == 1'b1 && rise_k < 0) rise_k = k;
            if (long_press) n_long++;
        end
        check("release_latency", rise_k, 2 + DB);
        check("long_count_after_release", n_long, exp_long_n);

        // bouncy press and bouncy release give one debounced press
        prev = B_clean; n_fall = 0; n_rise = 0;
        for (int k = 0; k < 30; k++) begin
            b = (k < 6) ? logic'(k[0]) : 1'b0;
            step(1, b);
            if (prev && !B_clean) n_fall++;
            if (!prev && B_clean) n_rise++;
            prev = B_clean;
        end
        for (int k = 0; k < 30; k++) begin
            b = (k < 5) ? ~logic'(k[0]) : 1'b1;
            step(1, b);
            if (prev && !B_clean) n_fall++;
            if (!prev && B_clean) n_rise++;
            prev = B_clean;
        end
        check("bounce_falls", n_fall, 1);
        check("bounce_rises", n_rise, 1);

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
